instr_encoder: RTL
==================

# instr_encoder

Instruction encoder and instruction-memory loader: the encoding counterpart of the main control unit's opcode decode. Accepts symbolic instruction requests (kind plus register/immediate fields) over a valid/ready handshake, packs each into a 32-bit MIPS word, and writes it sequentially into instruction memory through a write/acknowledge port. Used by the program loader and self-test path to fill instruction memory before the datapath runs.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after reset or `start`

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  synchronous restart: pointer to BASE_ADDR, clear count/err/full, abort pending write
- req_valid  in  1  request present
- req_ready  out  1  request accepted on an edge where valid & ready
- req_kind  in  3  0 R-type, 1 LW, 2 SW, 3 BEQ, 4 JUMP, 5 ADDI, 6–7 invalid
- req_rs, req_rt, req_rd, req_shamt  in  5 each  register/shift fields
- req_funct  in  6  R-type function field
- req_imm  in  16  I-type immediate
- req_target  in  26  J-type target
- imem_we  out  1  write request to instruction memory
- imem_addr  out  ADDR_WIDTH  word address of current write
- imem_wdata  out  32  encoded instruction
- imem_ack  in  1  memory accepts write on an edge where imem_we & imem_ack
- count  out  ADDR_WIDTH+1  words written since reset/start
- err  out  1  sticky: an invalid kind was accepted
- full  out  1  2^ADDR_WIDTH words written; no further requests accepted

## Operation
- Packing: R {000000,rs,rt,rd,shamt,funct}; LW {100011,rs,rt,imm}; SW {101011,rs,rt,imm}; BEQ {000100,rs,rt,imm}; JUMP {000010,target}; ADDI {001000,rs,rt,imm}.
- FSM states IDLE, WRITE. Reset → IDLE.
- req_ready = (state==IDLE) & !full & !start (combinational).
- IDLE, valid kind accepted: register packed word into imem_wdata → WRITE.
- IDLE, invalid kind accepted: set err, no write, count unchanged, stay IDLE.
- WRITE: imem_we=1; imem_addr, imem_wdata held stable until ack. On ack: imem_addr+1 (mod 2^ADDR_WIDTH), count+1, → IDLE.
- full asserts when count reaches 2^ADDR_WIDTH; held until start/reset.
- start (any state) wins over everything: → IDLE, imem_we=0, imem_addr=BASE_ADDR, count=0, err=0, full=0; a same-cycle ack is discarded (count not incremented).
- Reset values: imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, count 0, err 0, full 0; req_ready 1 once rst_n high.

## Timing
- Accept at edge N → imem_we and word valid from cycle N+1.
- Ack at edge M → imem_we low in cycle M+1, req_ready high in M+1 (unless full).
- Peak throughput one instruction per 2 cycles (zero-wait ack).
- rst_n low clears all state immediately (asynchronous), including mid-WRITE.
- Field inputs sampled only at the acceptance edge.

## Structure
- Shared package: opcode constants (R/LW/SW/BEQ/J/ADDI), req_kind encodings, state encoding; the control unit uses the same opcode constants.
- One sub-module: `instr_pack`, purely combinational (kind + fields → 32-bit word, kind_valid flag); FSM, pointer and counters in `instr_encoder`.

## Test plan
- Reset, R-type rs=1 rt=2 rd=3 shamt=0 funct=0x20, ack immediate → imem_wdata=0x00221820 at addr 0, count=1, 2 cycles to ready.
- LW rs=0 rt=8 imm=0x0004, ack delayed 3 cycles → 0x8C080004 held stable with imem_we=1, req_ready=0 throughout; addr increments only at ack.
- JUMP target=0x0000010 → 0x08000010; SW rs=29 rt=31 imm=0x0008 → 0xAFBF0008.
- Kind 6 then BEQ rs=1 rt=2 imm=0xFFFF → err=1, no imem_we for kind 6, then 0x1022FFFF at next address, count +1 only.
- ADDR_WIDTH=2: four writes → full=1, req_ready=0, imem_addr wrapped to 0; start → full=0, count=0, err=0, ready=1.
- start asserted with ack in WRITE → write discarded, count unchanged; rst_n low mid-WRITE → imem_we drops same cycle, all outputs at reset values.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for instruction packing.
// Opcodes match the control unit's decode table.
package instr_encoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] K_R    = 3'd0;
  localparam logic [2:0] K_LW   = 3'd1;
  localparam logic [2:0] K_SW   = 3'd2;
  localparam logic [2:0] K_BEQ  = 3'd3;
  localparam logic [2:0] K_J    = 3'd4;
  localparam logic [2:0] K_ADDI = 3'd5;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } instr_req_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bundle.
// master = requester/memory side, slave = encoder.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_kind;
  logic [4:0]            req_rs;
  logic [4:0]            req_rt;
  logic [4:0]            req_rd;
  logic [4:0]            req_shamt;
  logic [5:0]            req_funct;
  logic [15:0]           req_imm;
  logic [25:0]           req_target;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  imem_ack;

  modport master (
    output req_valid, req_kind, req_rs, req_rt,
    output req_rd, req_shamt, req_funct,
    output req_imm, req_target, imem_ack,
    input  req_ready, imem_we, imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  req_valid, req_kind, req_rs, req_rt,
    input  req_rd, req_shamt, req_funct,
    input  req_imm, req_target, imem_ack,
    output req_ready, imem_we, imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational MIPS word packer.
// Kinds 6-7 yield word 0 with kind_valid_o low.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  instr_req_t  req_i,
  output logic [31:0] word_o,
  output logic        kind_valid_o
);

  // select field layout from the request kind
  always_comb begin
    word_o       = '0;
    kind_valid_o = 1'b1;
    unique case (1'b1)
      (req_i.kind == K_R):
        word_o = {OP_RTYPE, req_i.rs, req_i.rt,
                  req_i.rd, req_i.shamt, req_i.funct};
      (req_i.kind == K_LW):
        word_o = {OP_LW, req_i.rs, req_i.rt, req_i.imm};
      (req_i.kind == K_SW):
        word_o = {OP_SW, req_i.rs, req_i.rt, req_i.imm};
      (req_i.kind == K_BEQ):
        word_o = {OP_BEQ, req_i.rs, req_i.rt, req_i.imm};
      (req_i.kind == K_J):
        word_o = {OP_J, req_i.target};
      (req_i.kind == K_ADDI):
        word_o = {OP_ADDI, req_i.rs, req_i.rt, req_i.imm};
      default:
        kind_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder and sequential imem loader.
// One word in flight; start restarts the load pointer.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  instr_encoder_if.slave      bus,
  output logic [ADDR_WIDTH:0] count,
  output logic                err,
  output logic                full
);

  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] CAP =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  err_q, err_d;
  logic                  full_q, full_d;

  instr_req_t req;
  logic [31:0] word;
  logic        kind_valid;
  logic        ready;
  logic        accept;

  assign req = '{
    kind:   bus.req_kind,
    rs:     bus.req_rs,
    rt:     bus.req_rt,
    rd:     bus.req_rd,
    shamt:  bus.req_shamt,
    funct:  bus.req_funct,
    imm:    bus.req_imm,
    target: bus.req_target
  };

  instr_pack u_pack (
    .req_i        (req),
    .word_o       (word),
    .kind_valid_o (kind_valid)
  );

  assign ready  = (state_q == ST_IDLE) & ~full_q & ~start;
  assign accept = bus.req_valid & ready;

  assign bus.req_ready  = ready;
  assign bus.imem_we    = (state_q == ST_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign count          = count_q;
  assign err            = err_q;
  assign full           = full_q;

  // next-state: start overrides; else accept or retire
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    full_d  = full_q;
    if (start) begin
      state_d = ST_IDLE;
      addr_d  = BASE;
      count_d = '0;
      err_d   = 1'b0;
      full_d  = 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == ST_IDLE): begin
          if (accept) begin
            if (kind_valid) begin
              wdata_d = word;
              state_d = ST_WRITE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        (state_q == ST_WRITE): begin
          if (bus.imem_ack) begin
            addr_d  = addr_q + 1'b1;
            count_d = count_q + 1'b1;
            full_d  = (count_q + 1'b1) == CAP;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
      full_q  <= full_d;
    end
  end

endmodule
